// File: rtl/uart_frame_ctrl.sv
// uart_frame_ctrl: assembles SOF/OPC/A/B/CHK frames from UART bytes, issues one ALU request, returns status + result bytes
// Ports: clk, i_rst (async, active-high); i_rx_data/i_rx_done receive side; o_tx_start/o_tx_data/i_tx_done transmit side;
//        o_op/o_opA/o_opB/o_valid ALU request, i_result combinational ALU result; o_busy, o_err_timeout, o_rx_overrun status.
module uart_frame_ctrl #(
  parameter int NB_DATA = 8,
  parameter int N_BYTES = 2,
  parameter int NB_OP = 6,
  parameter logic [NB_DATA-1:0] SOF = 8'hA5,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic                       clk,
  input  logic                       i_rst,
  input  logic [NB_DATA-1:0]         i_rx_data,
  input  logic                       i_rx_done,
  input  logic                       i_tx_done,
  output logic                       o_tx_start,
  output logic [NB_DATA-1:0]         o_tx_data,
  output logic [NB_OP-1:0]           o_op,
  output logic [NB_DATA*N_BYTES-1:0] o_opA,
  output logic [NB_DATA*N_BYTES-1:0] o_opB,
  output logic                       o_valid,
  input  logic [NB_DATA*N_BYTES-1:0] i_result,
  output logic                       o_busy,
  output logic                       o_err_timeout,
  output logic                       o_rx_overrun
);
  localparam int W = NB_DATA * N_BYTES;
  localparam int CW = $clog2(N_BYTES + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int RW = (N_BYTES + 1) * NB_DATA;
  typedef enum logic [2:0] {S_IDLE, S_OPC, S_OPA, S_OPB, S_CHK, S_EXEC, S_TX_LOAD, S_TX_WAIT} state_t;
  state_t state_q, state_d;
  logic [NB_OP-1:0] op_q, op_d, sop_q, sop_d;
  logic [W-1:0] opa_q, opa_d, opb_q, opb_d, sa_q, sa_d, sb_q, sb_d;
  logic [NB_DATA-1:0] chk_q, chk_d, st_q, st_d;
  logic opc_bad_q, opc_bad_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [RW-1:0] resp_q, resp_d;
  logic in_frame, expired, byte_last, tx_last;
  assign in_frame = state_q inside {S_OPC, S_OPA, S_OPB, S_CHK};
  assign expired = in_frame && !i_rx_done && tmo_q == TW'(TIMEOUT_CYC - 1);
  assign byte_last = cnt_q == CW'(N_BYTES - 1);
  assign tx_last = cnt_q == CW'(N_BYTES);
  assign o_busy = state_q != S_IDLE;
  assign o_tx_start = state_q == S_TX_LOAD;
  assign o_tx_data = resp_q[RW-1 -: NB_DATA];
  assign o_valid = state_q == S_EXEC && st_q == '0;
  assign o_err_timeout = expired;
  assign o_rx_overrun = i_rx_done && state_q inside {S_EXEC, S_TX_LOAD, S_TX_WAIT};
  assign o_op = op_q;
  assign o_opA = opa_q;
  assign o_opB = opb_q;
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    opa_d = opa_q;
    opb_d = opb_q;
    sop_d = sop_q;
    sa_d = sa_q;
    sb_d = sb_q;
    chk_d = chk_q;
    st_d = st_q;
    opc_bad_d = opc_bad_q;
    cnt_d = cnt_q;
    resp_d = resp_q;
    // a byte arriving on the expiry cycle wins: the counter restarts instead of aborting
    tmo_d = (in_frame && !i_rx_done && !expired) ? tmo_q + 1'b1 : '0;
    case (state_q)
      S_IDLE: state_d = (i_rx_done && i_rx_data == SOF) ? S_OPC : S_IDLE;
      S_OPC: if (i_rx_done) begin
        sop_d = i_rx_data[NB_OP-1:0];
        opc_bad_d = (i_rx_data >> NB_OP) != '0;
        chk_d = i_rx_data;
        cnt_d = '0;
        state_d = S_OPA;
      end
      S_OPA: if (i_rx_done) begin
        sa_d = (sa_q << NB_DATA) | W'(i_rx_data);
        chk_d = chk_q ^ i_rx_data;
        cnt_d = byte_last ? '0 : cnt_q + 1'b1;
        state_d = byte_last ? S_OPB : S_OPA;
      end
      S_OPB: if (i_rx_done) begin
        sb_d = (sb_q << NB_DATA) | W'(i_rx_data);
        chk_d = chk_q ^ i_rx_data;
        cnt_d = byte_last ? '0 : cnt_q + 1'b1;
        state_d = byte_last ? S_CHK : S_OPB;
      end
      // operands are assembled in shadow registers so an aborted frame leaves the ALU inputs untouched
      S_CHK: if (i_rx_done) begin
        st_d = (i_rx_data != chk_q) ? NB_DATA'(1) : opc_bad_q ? NB_DATA'(2) : '0;
        op_d = sop_q;
        opa_d = sa_q;
        opb_d = sb_q;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        resp_d = {st_q, (st_q == '0) ? i_result : W'(0)};
        cnt_d = '0;
        state_d = S_TX_LOAD;
      end
      S_TX_LOAD: state_d = S_TX_WAIT;
      S_TX_WAIT: if (i_tx_done) begin
        resp_d = resp_q << NB_DATA;
        cnt_d = tx_last ? '0 : cnt_q + 1'b1;
        state_d = tx_last ? S_IDLE : S_TX_LOAD;
      end
      default: state_d = S_IDLE;
    endcase
    if (expired) state_d = S_IDLE;
  end
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      op_q <= '0;
      opa_q <= '0;
      opb_q <= '0;
      sop_q <= '0;
      sa_q <= '0;
      sb_q <= '0;
      chk_q <= '0;
      st_q <= '0;
      opc_bad_q <= 1'b0;
      cnt_q <= '0;
      tmo_q <= '0;
      resp_q <= '0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      opa_q <= opa_d;
      opb_q <= opb_d;
      sop_q <= sop_d;
      sa_q <= sa_d;
      sb_q <= sb_d;
      chk_q <= chk_d;
      st_q <= st_d;
      opc_bad_q <= opc_bad_d;
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
      resp_q <= resp_d;
    end
  end
endmodule

// File: tb/tb_uart_frame_ctrl.sv
// tb_uart_frame_ctrl: directed frames with a queue scoreboard checked by independent monitor processes
module tb_uart_frame_ctrl;
  localparam int TMO = 40;
  logic clk = 1'b0, i_rst = 1'b1, i_rx_done = 1'b0, i_tx_done = 1'b0;
  logic [7:0] i_rx_data = 8'h00;
  logic o_tx_start, o_valid, o_busy, o_err_timeout, o_rx_overrun;
  logic [7:0] o_tx_data;
  logic [5:0] o_op;
  logic [15:0] o_opA, o_opB, i_result;
  int n_chk = 0, n_err = 0, n_tmo = 0, n_ovr = 0, n_start = 0;
  logic [7:0] exp_tx[$];
  logic [37:0] exp_v[$];
  logic [7:0] held;
  uart_frame_ctrl #(.NB_DATA(8), .N_BYTES(2), .NB_OP(6), .SOF(8'hA5), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .i_rst(i_rst), .i_rx_data(i_rx_data), .i_rx_done(i_rx_done), .i_tx_done(i_tx_done),
    .o_tx_start(o_tx_start), .o_tx_data(o_tx_data), .o_op(o_op), .o_opA(o_opA), .o_opB(o_opB),
    .o_valid(o_valid), .i_result(i_result), .o_busy(o_busy), .o_err_timeout(o_err_timeout),
    .o_rx_overrun(o_rx_overrun)
  );
  assign i_result = o_opA + o_opB;
  always #5 clk = ~clk;
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask
  initial forever begin
    @(negedge clk);
    if (o_valid) begin
      if (exp_v.size() == 0) check("valid_unexpected", 64'(o_valid), 64'd0);
      else check("valid_ops", 64'({o_op, o_opA, o_opB}), 64'(exp_v.pop_front()));
    end
    if (o_tx_start) begin
      n_start++;
      if (exp_tx.size() == 0) check("tx_unexpected", 64'(o_tx_start), 64'd0);
      else check("tx_byte", 64'(o_tx_data), 64'(exp_tx.pop_front()));
    end
    if (o_err_timeout) n_tmo++;
    if (o_rx_overrun) n_ovr++;
  end
  initial forever begin
    @(negedge clk);
    i_tx_done = 1'b0;
    if (o_tx_start) begin
      held = o_tx_data;
      repeat (3) begin
        @(negedge clk);
        if (o_busy) check("tx_hold", 64'(o_tx_data), 64'(held));
        if (o_busy) check("tx_no_restart", 64'(o_tx_start), 64'd0);
      end
      i_tx_done = 1'b1;
    end
  end
  task automatic send_byte(input logic [7:0] b);
    i_rx_data = b;
    i_rx_done = 1'b1;
    @(posedge clk);
    #1 i_rx_done = 1'b0;
  endtask
  task automatic send_frame(input logic [55:0] f);
    for (int i = 6; i >= 0; i--) send_byte(f[i*8 +: 8]);
  endtask
  task automatic expect_resp(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    exp_tx.push_back(b0);
    exp_tx.push_back(b1);
    exp_tx.push_back(b2);
  endtask
  task automatic wait_idle(input string nm);
    int k = 0;
    while (o_busy && k < 300) begin
      @(posedge clk);
      #1 k++;
    end
    check(nm, 64'(o_busy), 64'd0);
  endtask
  task automatic wait_starts(input int target);
    int k = 0;
    while (n_start < target && k < 300) begin
      @(posedge clk);
      #1 k++;
    end
    check("start_wait", 64'(n_start >= target), 64'd1);
  endtask
  task automatic check_reset_outputs(input string nm);
    check({nm, "_tx_start"}, 64'(o_tx_start), 64'd0);
    check({nm, "_tx_data"}, 64'(o_tx_data), 64'd0);
    check({nm, "_op"}, 64'(o_op), 64'd0);
    check({nm, "_opA"}, 64'(o_opA), 64'd0);
    check({nm, "_opB"}, 64'(o_opB), 64'd0);
    check({nm, "_valid"}, 64'(o_valid), 64'd0);
    check({nm, "_busy"}, 64'(o_busy), 64'd0);
    check({nm, "_err_timeout"}, 64'(o_err_timeout), 64'd0);
    check({nm, "_rx_overrun"}, 64'(o_rx_overrun), 64'd0);
  endtask
  initial begin
    int s0;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    i_rst = 1'b0;
    @(posedge clk);
    #1;
    exp_v.push_back({6'h20, 16'h1234, 16'h0001});
    expect_resp(8'h00, 8'h12, 8'h35);
    send_frame(56'hA5_20_12_34_00_01_07);
    check("valid_latency", 64'(o_valid), 64'd1);
    @(posedge clk);
    #1 check("start_latency", 64'(o_tx_start), 64'd1);
    wait_idle("idle_good");
    expect_resp(8'h01, 8'h00, 8'h00);
    send_frame(56'hA5_20_12_34_00_01_08);
    wait_idle("idle_badchk");
    expect_resp(8'h02, 8'h00, 8'h00);
    send_frame(56'hA5_C0_12_34_00_01_E7);
    wait_idle("idle_badop");
    s0 = n_start;
    send_byte(8'hA5);
    send_byte(8'h20);
    send_byte(8'h12);
    check("partial_busy", 64'(o_busy), 64'd1);
    repeat (TMO + 10) @(posedge clk);
    #1 check("timeout_pulses", 64'(n_tmo), 64'd1);
    check("timeout_idle", 64'(o_busy), 64'd0);
    check("timeout_no_tx", 64'(n_start), 64'(s0));
    exp_v.push_back({6'h05, 16'hFFFF, 16'h0002});
    expect_resp(8'h00, 8'h00, 8'h01);
    send_frame(56'hA5_05_FF_FF_00_02_07);
    wait_idle("idle_wrap");
    exp_v.push_back({6'h01, 16'hA500, 16'h00A5});
    expect_resp(8'h00, 8'hA5, 8'hA5);
    send_frame(56'hA5_01_A5_00_00_A5_01);
    wait_idle("idle_sof_payload");
    s0 = n_start;
    send_byte(8'h55);
    check("junk55_busy", 64'(o_busy), 64'd0);
    send_byte(8'h00);
    check("junk00_busy", 64'(o_busy), 64'd0);
    repeat (5) @(posedge clk);
    #1 check("junk_no_tx", 64'(n_start), 64'(s0));
    check("junk_no_timeout", 64'(n_tmo), 64'd1);
    s0 = n_start;
    exp_v.push_back({6'h20, 16'h1234, 16'h0001});
    expect_resp(8'h00, 8'h12, 8'h35);
    send_frame(56'hA5_20_12_34_00_01_07);
    wait_starts(s0 + 1);
    send_byte(8'h5A);
    check("overrun_pulses", 64'(n_ovr), 64'd1);
    wait_idle("idle_overrun");
    s0 = n_start;
    exp_v.push_back({6'h20, 16'h1234, 16'h0001});
    exp_tx.push_back(8'h00);
    exp_tx.push_back(8'h12);
    send_frame(56'hA5_20_12_34_00_01_07);
    wait_starts(s0 + 2);
    i_rst = 1'b1;
    #2 check_reset_outputs("midreset");
    repeat (2) @(posedge clk);
    #1 i_rst = 1'b0;
    repeat (20) @(posedge clk);
    #1 check("reset_no_third_start", 64'(n_start), 64'(s0 + 2));
    check("reset_stays_idle", 64'(o_busy), 64'd0);
    check("exp_tx_left", 64'(exp_tx.size()), 64'd0);
    check("exp_valid_left", 64'(exp_v.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/uart_frame_ctrl.md
# uart_frame_ctrl

Parametrised frame controller between the byte-level UART receiver/transmitter and the ALU. It assembles multi-byte command frames (start byte, opcode, two N_BYTES-wide operands, XOR checksum) from received bytes and drives one ALU request per valid frame. It then serialises a status byte plus the multi-byte result back through the UART transmitter with a start/done handshake. It replaces the single-byte interface with wide operands, frame validation, inter-byte timeout and error reporting.

## Interface

- NB_DATA, 8, UART byte width
- N_BYTES, 2, bytes per operand and per result (operand width W = NB_DATA*N_BYTES)
- NB_OP, 6, ALU opcode width (NB_OP <= NB_DATA)
- SOF, 8'hA5, start-of-frame byte value
- TIMEOUT_CYC, 1_000_000, maximum clock cycles allowed between consecutive frame bytes
- clk  in  1  system clock; the block uses one clock only
- i_rst  in  1  reset; asynchronous and active-high
- i_rx_data  in  NB_DATA  received byte, valid when i_rx_done=1
- i_rx_done  in  1  one-cycle strobe, new byte received
- i_tx_done  in  1  one-cycle strobe, transmitter finished the current byte
- o_tx_start  out  1  one-cycle pulse, transmit o_tx_data
- o_tx_data  out  NB_DATA  byte to transmit; held stable from o_tx_start until i_tx_done
- o_op  out  NB_OP  ALU opcode
- o_opA, o_opB  out  W  ALU operands
- o_valid  out  1  one-cycle ALU request strobe
- i_result  in  W  ALU result; combinational from o_op/o_opA/o_opB
- o_busy  out  1  high in any state other than IDLE
- o_err_timeout  out  1  one-cycle pulse when a frame is aborted by timeout
- o_rx_overrun  out  1  one-cycle pulse when a byte arrives during EXEC/TX states and is dropped

## Operation

- Frame format: SOF, OPC, A[MSB..LSB] (N_BYTES bytes), B[MSB..LSB] (N_BYTES bytes), CHK.
  - CHK is the XOR of OPC and all operand bytes. SOF is excluded from CHK.
- States: IDLE, OPC, OPA, OPB, CHK, EXEC, TX_LOAD, TX_WAIT.
- IDLE: on i_rx_done with i_rx_data==SOF, go to OPC. Any other byte is ignored without flags.
- OPC: latch the byte and init the checksum with it, then go to OPA.
- OPA and OPB: shift each byte into the operand register, MSB first. A byte counter advances to the next state after N_BYTES bytes.
  - A byte equal to SOF inside the payload is data, not a restart.
- CHK: compare the received byte with the running XOR.
  - Status 8'h00: checksum OK and OPC[NB_DATA-1:NB_OP]==0.
  - Status 8'h01: checksum mismatch. This has priority over 8'h02.
  - Status 8'h02: nonzero upper opcode bits.
  - Go to EXEC.
- EXEC, one cycle:
  - Status 00: assert o_valid and register i_result on this edge.
  - Otherwise: o_valid stays low and the result register is cleared to 0.
  - Go to TX_LOAD.
- TX_LOAD: pulse o_tx_start with the next response byte, then go to TX_WAIT.
  - Response is status byte, then result MSB..LSB, for 1+N_BYTES bytes in total.
- TX_WAIT: on i_tx_done, return to TX_LOAD if bytes remain, else go to IDLE.
- Timeout:
  - Counter clears on every accepted i_rx_done in OPC..CHK.
  - On reaching TIMEOUT_CYC-1 without a byte: pulse o_err_timeout, discard the partial frame, go to IDLE. No response is sent.
  - The counter is idle outside OPC..CHK.
- Simultaneous i_rx_done and timeout expiry: the byte wins and the counter clears.
- i_rx_done in EXEC, TX_LOAD or TX_WAIT: the byte is dropped and o_rx_overrun pulses.
- o_op, o_opA and o_opB hold their last frame values until the next frame overwrites them.

## Timing

- Reset, asynchronous: state=IDLE, all counters and registers 0. Outputs: o_tx_start=0, o_tx_data=0, o_op=0, o_opA=0, o_opB=0, o_valid=0, o_busy=0, o_err_timeout=0, o_rx_overrun=0.
- Reset mid-transmission: the block returns to IDLE immediately. It issues no further o_tx_start. A later i_tx_done is ignored.
- CHK byte strobe to o_valid: 1 cycle. o_valid to first o_tx_start: 1 cycle.
- o_tx_start is never reasserted before i_tx_done for the previous byte.
- i_tx_done arriving outside TX_WAIT is ignored.
- Back-to-back frames: a SOF arriving in the same cycle as IDLE entry is accepted.

## Test plan

- N_BYTES=2, ALU stub adds A+B. Send A5 20 12 34 00 01 07. Expect:
  - o_valid with o_op=0x20, o_opA=0x1234, o_opB=0x0001.
  - Response bytes 00 12 35.
- Same frame with CHK=0x08: expect no o_valid and response 01 00 00.
- Opcode byte 0xC0 with correct CHK: expect response 02 00 00 and no o_valid.
- Send A5 20 12 then idle for TIMEOUT_CYC cycles: expect one o_err_timeout pulse and no o_tx_start. A following valid frame completes normally.
- Inject a received byte during TX_WAIT: expect an o_rx_overrun pulse and the response unaltered. Bytes 55 and 00 in IDLE produce no activity.
- Assert i_rst after the second response byte: expect outputs at reset values and no third o_tx_start.
